// File: rtl/seq_mult16.sv
// Sequential 16x16 shift-and-add multiplier returning (a*b) mod 2^16, plus the
// 16-bit carry-lookahead adder `circuit` that performs every partial-sum addition.

module circuit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);
  // Carry-in is zero and carry-out is dropped, so the top generate bit and
  // the last group's lookahead terms are never needed.
  logic [14:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [2:0]  gg;
  logic [2:0]  gp;
  logic [3:0]  gc;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    c  = '0;
    gg = '0;
    gp = '0;
    gc = '0;
    g  = a[14:0] & b[14:0];
    p  = a ^ b;
    for (int j = 0; j < 3; j++) begin
      gp[j] = &p[4*j +: 4];
      gg[j] = g[4*j+3]
            | (p[4*j+3] & g[4*j+2])
            | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
    end
    for (int j = 0; j < 3; j++) begin
      gc[j+1] = gg[j] | (gp[j] & gc[j]);
    end
    for (int j = 0; j < 4; j++) begin
      c[4*j] = gc[j];
      for (int k = 1; k < 4; k++) begin
        c[4*j+k] = g[4*j+k-1] | (p[4*j+k-1] & c[4*j+k-1]);
      end
    end
    sum = p ^ c;
  end
endmodule

module seq_mult16 #(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] o
);
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t      state, next_state;
  logic [15:0] mcand, mplier, acc;
  logic [3:0]  cnt;
  logic [15:0] add_sum;
  logic [15:0] acc_next;
  logic        accept;
  logic        last_iter;

  circuit u_add (
    .a   (acc),
    .b   (mcand),
    .sum (add_sum)
  );

  assign acc_next  = mplier[0] ? add_sum : acc;
  assign last_iter = (cnt == 4'd15) || (EARLY_EXIT && (mplier[15:1] == 15'd0));

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      ST_IDLE: if (start) begin
        accept     = 1'b1;
        next_state = ST_RUN;
      end
      ST_RUN:  if (last_iter) next_state = ST_DONE;
      ST_DONE: begin
        accept     = start;
        next_state = start ? ST_RUN : ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!nrst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state == ST_RUN);
      done  <= (next_state == ST_DONE);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      o      <= '0;
    end else if (accept) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == ST_RUN) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 4'd1;
      // o only moves on the final iteration, so a new start leaves the old result visible.
      if (last_iter) o <= acc_next;
    end
  end
endmodule

// File: tb/tb_seq_mult16.sv
// Self-checking bench for seq_mult16: one DUT with early exit, one without,
// each checked against an arithmetic product / iteration-count model.

module tb_seq_mult16;
  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        start_v [2];
  logic [15:0] a_v     [2];
  logic [15:0] b_v     [2];
  logic        busy_v  [2];
  logic        done_v  [2];
  logic [15:0] o_v     [2];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  seq_mult16 #(.EARLY_EXIT(1'b0)) dut0 (
    .clk(clk), .nrst(nrst), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .o(o_v[0])
  );

  seq_mult16 #(.EARLY_EXIT(1'b1)) dut1 (
    .clk(clk), .nrst(nrst), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .o(o_v[1])
  );

  // Reference: product mod 2^16 and latency from the highest set bit of b.
  function automatic logic [15:0] exp_prod(input logic [15:0] av, input logic [15:0] bv);
    logic [31:0] p;
    p = 32'(av) * 32'(bv);
    return p[15:0];
  endfunction

  function automatic int exp_n(input int sel, input logic [15:0] bv);
    int n;
    n = 1;
    if (sel == 0) return 16;
    for (int i = 0; i < 16; i++) if (bv[i]) n = i + 1;
    return n;
  endfunction

  // Launch one multiply and check busy span, latency, result, done width and hold.
  task automatic run_op(input int sel, input logic [15:0] av, input logic [15:0] bv, input string tag);
    int          n_exp, cycles;
    logic [15:0] p_exp;
    bit          busy_ok;
    n_exp   = exp_n(sel, bv);
    p_exp   = exp_prod(av, bv);
    busy_ok = 1'b1;
    @(negedge clk);
    a_v[sel] = av; b_v[sel] = bv; start_v[sel] = 1'b1;
    @(negedge clk);
    start_v[sel] = 1'b0; a_v[sel] = ~av; b_v[sel] = ~bv;
    cycles = 0;
    while (done_v[sel] !== 1'b1 && cycles < 40) begin
      if (busy_v[sel] !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      cycles++;
    end
    total++;
    if (busy_ok !== 1'b1) $display("FAIL %s busy_span dut%0d: busy dropped before done", tag, sel);
    else passed++;
    total++;
    if (cycles !== n_exp) $display("FAIL %s latency dut%0d: got %0d want %0d", tag, sel, cycles, n_exp);
    else passed++;
    total++;
    if (busy_v[sel] !== 1'b0) $display("FAIL %s busy_at_done dut%0d: got %b want 0", tag, sel, busy_v[sel]);
    else passed++;
    total++;
    if (o_v[sel] !== p_exp) $display("FAIL %s result dut%0d: got %h want %h", tag, sel, o_v[sel], p_exp);
    else passed++;
    @(negedge clk);
    total++;
    if (done_v[sel] !== 1'b0) $display("FAIL %s done_width dut%0d: got %b want 0", tag, sel, done_v[sel]);
    else passed++;
    total++;
    if (o_v[sel] !== p_exp) $display("FAIL %s result_hold dut%0d: got %h want %h", tag, sel, o_v[sel], p_exp);
    else passed++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      total++;
      if ({busy_v[s], done_v[s], o_v[s]} !== 18'h0)
        $display("FAIL reset_values dut%0d: busy=%b done=%b o=%h want 0/0/0000", s, busy_v[s], done_v[s], o_v[s]);
      else passed++;
    end
    nrst = 1'b1;
  endtask

  task automatic test_directed();
    run_op(1, 16'd3, 16'd5, "small_3x5");
    run_op(1, 16'hBEEF, 16'h0000, "b_zero");
    run_op(1, 16'hFFFF, 16'hFFFF, "wrap_ffff");
    run_op(0, 16'hFFFF, 16'hFFFF, "wrap_ffff");
    run_op(1, 16'd300, 16'd300, "wrap_300");
    run_op(1, 16'h1234, 16'h0100, "iter_count");
    run_op(0, 16'h1234, 16'h0100, "iter_count");
  endtask

  task automatic test_ignore_start();
    logic [15:0] prev, p_exp;
    int          cycles;
    prev  = o_v[1];
    p_exp = exp_prod(16'h1234, 16'h8001);
    @(negedge clk);
    a_v[1] = 16'h1234; b_v[1] = 16'h8001; start_v[1] = 1'b1;
    @(negedge clk);
    start_v[1] = 1'b0;
    repeat (4) @(negedge clk);
    a_v[1] = 16'd5; b_v[1] = 16'd5; start_v[1] = 1'b1;
    @(negedge clk);
    start_v[1] = 1'b0;
    total++;
    if (o_v[1] !== prev) $display("FAIL ignore_o_hold: got %h want %h", o_v[1], prev);
    else passed++;
    cycles = 0;
    while (done_v[1] !== 1'b1 && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    total++;
    if (o_v[1] !== p_exp) $display("FAIL ignore_result: got %h want %h", o_v[1], p_exp);
    else passed++;
    @(negedge clk);
    total++;
    if (busy_v[1] !== 1'b0) $display("FAIL ignore_no_relaunch: busy got %b want 0", busy_v[1]);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int cycles;
    @(negedge clk);
    a_v[1] = 16'd3; b_v[1] = 16'd5; start_v[1] = 1'b1;
    @(negedge clk);
    a_v[1] = 16'd7; b_v[1] = 16'd9;
    cycles = 0;
    while (done_v[1] !== 1'b1 && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    total++;
    if (o_v[1] !== 16'h000F) $display("FAIL b2b_first: got %h want 000f", o_v[1]);
    else passed++;
    @(negedge clk);
    start_v[1] = 1'b0;
    total++;
    if (busy_v[1] !== 1'b1 || done_v[1] !== 1'b0)
      $display("FAIL b2b_relaunch: busy=%b done=%b want 1/0", busy_v[1], done_v[1]);
    else passed++;
    total++;
    if (o_v[1] !== 16'h000F) $display("FAIL b2b_o_hold: got %h want 000f", o_v[1]);
    else passed++;
    cycles = 0;
    while (done_v[1] !== 1'b1 && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    total++;
    if (cycles !== 4) $display("FAIL b2b_latency: got %0d want 4", cycles);
    else passed++;
    total++;
    if (o_v[1] !== 16'h003F) $display("FAIL b2b_second: got %h want 003f", o_v[1]);
    else passed++;
  endtask

  task automatic test_reset_midrun();
    bit saw_done;
    saw_done = 1'b0;
    @(negedge clk);
    a_v[1] = 16'hFFFF; b_v[1] = 16'hFFFF; start_v[1] = 1'b1;
    @(negedge clk);
    start_v[1] = 1'b0;
    repeat (5) @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    total++;
    if ({busy_v[1], done_v[1], o_v[1]} !== 18'h0)
      $display("FAIL async_reset: busy=%b done=%b o=%h want 0/0/0000", busy_v[1], done_v[1], o_v[1]);
    else passed++;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done_v[1] === 1'b1) saw_done = 1'b1;
    end
    total++;
    if (saw_done !== 1'b0) $display("FAIL reset_no_done: got done pulse want none");
    else passed++;
    run_op(1, 16'd2, 16'd2, "after_reset");
  endtask

  task automatic test_random();
    logic [15:0] av, bv;
    for (int i = 0; i < 24; i++) begin
      av = 16'($urandom());
      bv = 16'($urandom()) >> $urandom_range(0, 15);
      run_op(i % 2, av, bv, "random");
    end
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      start_v[s] = 1'b0; a_v[s] = '0; b_v[s] = '0;
    end
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_midrun();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
